// File: rtl/pcm_wclk_lock_ctrl.sv
// WCLK period lock detector, MCLK/fs ratio classifier and output mute sequencer.
// Optional macro PCM_LOCK_MUTE_EN: hold mute for UNMUTE_FRAMES word clocks after lock.
module pcm_wclk_lock_ctrl #(
    parameter int CNT_WIDTH     = 12,
    parameter int LOCK_COUNT    = 4,
    parameter int TOL           = 1,
    parameter int UNMUTE_FRAMES = 16
) (
    input  logic                 MCLK_I,
    input  logic                 ARESETN_I,
    input  logic                 WCLK_I,
    output logic                 LOCK_O,
    output logic [CNT_WIDTH-1:0] PERIOD_O,
    output logic [2:0]           RATE_O,
    output logic                 MUTE_O
);

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH:0]   TOL_W   = (CNT_WIDTH + 1)'(TOL);
    localparam logic [3:0]           LOCK_N  = 4'(LOCK_COUNT);

    if (CNT_WIDTH < 11 || LOCK_COUNT < 2 || LOCK_COUNT > 15 || TOL < 0 || UNMUTE_FRAMES < 1) begin : g_param_err
        $error("pcm_wclk_lock_ctrl: parameter out of range");
    end

    function automatic logic [CNT_WIDTH:0] abs_diff(input logic [CNT_WIDTH-1:0] a,
                                                    input logic [CNT_WIDTH-1:0] b);
        logic [CNT_WIDTH:0] ae;
        logic [CNT_WIDTH:0] be;
        ae = {1'b0, a};
        be = {1'b0, b};
        return (ae >= be) ? (ae - be) : (be - ae);
    endfunction

    // Scanning downwards lets the lowest matching ratio win if TOL is wide.
    function automatic logic [2:0] rate_code(input logic [CNT_WIDTH-1:0] r);
        logic [2:0] code;
        code = 3'd7;
        for (int k = 4; k >= 0; k--) begin
            if (abs_diff(r, CNT_WIDTH'(32'd64 << k)) <= TOL_W) begin
                code = 3'(k + 1);
            end
        end
        return code;
    endfunction

    logic                 wclk_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] ref_q;
    logic [3:0]           run_q;
    state_t               state_q;
    logic                 lock_q;
    logic [CNT_WIDTH-1:0] period_q;
    logic [2:0]           rate_q;
    logic                 mute_q;
`ifdef PCM_LOCK_MUTE_EN
    localparam int UW = $clog2(UNMUTE_FRAMES + 1);
    logic [UW-1:0]        ucnt_q;
`endif

    logic                 edge_s;
    logic                 sat_s;
    logic [CNT_WIDTH:0]   ref_diff_s;
    logic [CNT_WIDTH:0]   per_diff_s;

    assign edge_s     = WCLK_I & ~wclk_q;
    assign sat_s      = (cnt_q == CNT_MAX);
    assign ref_diff_s = abs_diff(cnt_q, ref_q);
    assign per_diff_s = abs_diff(cnt_q, period_q);

    // WCLK delay tap and saturating period counter.
    always_ff @(posedge MCLK_I) begin
        if (!ARESETN_I) begin
            wclk_q <= 1'b0;
            cnt_q  <= {CNT_WIDTH{1'b0}};
        end else begin
            wclk_q <= WCLK_I;
            if (edge_s) begin
                cnt_q <= {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end else if (!sat_s) begin
                cnt_q <= cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end else begin
                cnt_q <= cnt_q;
            end
        end
    end

    // Lock FSM with registered lock, period, rate and mute outputs.
    always_ff @(posedge MCLK_I) begin
        if (!ARESETN_I) begin
            state_q  <= ST_SEARCH;
            ref_q    <= {CNT_WIDTH{1'b0}};
            run_q    <= 4'd0;
            lock_q   <= 1'b0;
            period_q <= {CNT_WIDTH{1'b0}};
            rate_q   <= 3'd0;
            mute_q   <= 1'b1;
`ifdef PCM_LOCK_MUTE_EN
            ucnt_q   <= {UW{1'b0}};
`endif
        end else begin
            case (state_q)
                ST_SEARCH: begin
                    if (edge_s) begin
                        state_q <= ST_MEASURE;
                        run_q   <= 4'd0;
                    end
                end
                ST_MEASURE: begin
                    if (edge_s) begin
                        if (run_q == 4'd0 || ref_diff_s > TOL_W) begin
                            ref_q <= cnt_q;
                            run_q <= 4'd1;
                        end else begin
                            run_q <= run_q + 4'd1;
                            if (run_q + 4'd1 == LOCK_N) begin
                                state_q  <= ST_LOCKED;
                                lock_q   <= 1'b1;
                                period_q <= ref_q;
                                rate_q   <= rate_code(ref_q);
`ifdef PCM_LOCK_MUTE_EN
                                ucnt_q   <= {UW{1'b0}};
`else
                                mute_q   <= 1'b0;
`endif
                            end
                        end
                    end else if (sat_s) begin
                        state_q <= ST_SEARCH;
                        run_q   <= 4'd0;
                    end
                end
                ST_LOCKED: begin
                    if (edge_s) begin
                        // In-tolerance edges leave PERIOD_O untouched; only a miss re-measures.
                        if (per_diff_s > TOL_W) begin
                            state_q  <= ST_MEASURE;
                            ref_q    <= cnt_q;
                            run_q    <= 4'd1;
                            lock_q   <= 1'b0;
                            period_q <= {CNT_WIDTH{1'b0}};
                            rate_q   <= 3'd0;
                            mute_q   <= 1'b1;
`ifdef PCM_LOCK_MUTE_EN
                            ucnt_q   <= {UW{1'b0}};
`endif
                        end else begin
`ifdef PCM_LOCK_MUTE_EN
                            if (mute_q) begin
                                if (ucnt_q + UW'(1) == UW'(UNMUTE_FRAMES)) begin
                                    mute_q <= 1'b0;
                                end else begin
                                    ucnt_q <= ucnt_q + UW'(1);
                                end
                            end
`endif
                        end
                    end else if (sat_s) begin
                        state_q  <= ST_SEARCH;
                        run_q    <= 4'd0;
                        lock_q   <= 1'b0;
                        period_q <= {CNT_WIDTH{1'b0}};
                        rate_q   <= 3'd0;
                        mute_q   <= 1'b1;
`ifdef PCM_LOCK_MUTE_EN
                        ucnt_q   <= {UW{1'b0}};
`endif
                    end
                end
                default: begin
                    state_q <= ST_SEARCH;
                end
            endcase
        end
    end

    assign LOCK_O   = lock_q;
    assign PERIOD_O = period_q;
    assign RATE_O   = rate_q;
    assign MUTE_O   = mute_q;

endmodule

// File: tb/tb_pcm_wclk_lock_ctrl.sv
// Table-driven bench for pcm_wclk_lock_ctrl with a queue scoreboard; each
// table row is one WCLK edge cycle plus the gap that follows it.
module tb_pcm_wclk_lock_ctrl;

    localparam int CW = 12;
`ifdef PCM_LOCK_MUTE_EN
    localparam bit MUTE_EN = 1'b1;
`else
    localparam bit MUTE_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rstn;
    logic          wclk;
    logic          lock_o;
    logic [CW-1:0] period_o;
    logic [2:0]    rate_o;
    logic          mute_o;

    always #5 clk = ~clk;

    pcm_wclk_lock_ctrl dut (
        .MCLK_I   (clk),
        .ARESETN_I(rstn),
        .WCLK_I   (wclk),
        .LOCK_O   (lock_o),
        .PERIOD_O (period_o),
        .RATE_O   (rate_o),
        .MUTE_O   (mute_o)
    );

    typedef struct {
        int            gap;
        logic          lock;
        logic [CW-1:0] period;
        logic [2:0]    rate;
        logic          mute;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Expected mute n edge cycles after the locking edge (n = 0 is the lock edge).
    function automatic logic mu(input int n);
        if (MUTE_EN) return (n < 16) ? 1'b1 : 1'b0;
        return 1'b0;
    endfunction

    function automatic vec_t mk(input int gap, input logic l, input int p, input int r, input logic m);
        vec_t v;
        v.gap    = gap;
        v.lock   = l;
        v.period = CW'(p);
        v.rate   = 3'(r);
        v.mute   = m;
        return v;
    endfunction

    task automatic add(input int gap, input logic l, input int p, input int r, input logic m);
        vecs.push_back(mk(gap, l, p, r, m));
    endtask

    task automatic cyc(input logic v);
        wclk = v;
        @(posedge clk);
        #1;
    endtask

    task automatic check1(input int id, input string f, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL step%0d %s: got %0d expected %0d", id, f, act, exp);
        end
    endtask

    task automatic compare_out(input int id);
        vec_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL step%0d scoreboard: got empty queue expected an entry", id);
        end else begin
            e = sb.pop_front();
            check1(id, "LOCK_O",   32'(lock_o),   32'(e.lock));
            check1(id, "PERIOD_O", 32'(period_o), 32'(e.period));
            check1(id, "RATE_O",   32'(rate_o),   32'(e.rate));
            check1(id, "MUTE_O",   32'(mute_o),   32'(e.mute));
        end
    endtask

    task automatic expect_now(input int id, input logic l, input int p, input int r, input logic m);
        sb.push_back(mk(0, l, p, r, m));
        compare_out(id);
    endtask

    // Edge cycle (checked right after it is sampled), then 50% duty for the rest of the gap.
    task automatic apply_edge(input int id, input vec_t v);
        sb.push_back(v);
        cyc(1'b1);
        compare_out(id);
        for (int i = 1; i < v.gap / 2; i++) cyc(1'b1);
        for (int i = 0; i < v.gap - v.gap / 2; i++) cyc(1'b0);
    endtask

    initial begin
        rstn = 1'b0;
        wclk = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        expect_now(0, 1'b0, 0, 0, 1'b1);
        rstn = 1'b1;
        repeat (4) cyc(1'b0);
        expect_now(1, 1'b0, 0, 0, 1'b1);

        // Steady 128: lock on edge 5, delayed unmute on edge 21 when enabled.
        for (int i = 0; i < 4; i++) add(128, 1'b0, 0, 0, 1'b1);
        add(128, 1'b1, 128, 2, mu(0));
        for (int n = 1; n <= 15; n++) add(128, 1'b1, 128, 2, mu(n));
        add(129, 1'b1, 128, 2, mu(16));
        add(131, 1'b1, 128, 2, mu(17));
        // 131 period unlocks; then jittered 128,129,127,128 relock at 128.
        add(128, 1'b0, 0, 0, 1'b1);
        add(129, 1'b0, 0, 0, 1'b1);
        add(127, 1'b0, 0, 0, 1'b1);
        add(128, 1'b0, 0, 0, 1'b1);
        add(131, 1'b1, 128, 2, mu(0));
        // Non-standard 384 ratio.
        add(384, 1'b0, 0, 0, 1'b1);
        for (int i = 0; i < 3; i++) add(384, 1'b0, 0, 0, 1'b1);
        add(128, 1'b1, 384, 7, mu(0));
        // Back to 128, then switch to 256.
        for (int i = 0; i < 3; i++) add(128, 1'b0, 0, 0, 1'b1);
        add(256, 1'b1, 128, 2, mu(0));
        for (int i = 0; i < 3; i++) add(256, 1'b0, 0, 0, 1'b1);
        add(256, 1'b1, 256, 3, mu(0));

        foreach (vecs[i]) apply_edge(100 + i, vecs[i]);

        // Timeout: one more in-tolerance edge, then WCLK stuck high.
        sb.push_back(mk(0, 1'b1, 256, 3, mu(1)));
        cyc(1'b1);
        compare_out(200);
        repeat (4094) cyc(1'b1);
        expect_now(201, 1'b1, 256, 3, mu(1));
        cyc(1'b1);
        expect_now(202, 1'b0, 0, 0, 1'b1);

        // Resume at 128: relock takes five edge cycles.
        repeat (64) cyc(1'b0);
        for (int i = 0; i < 4; i++) apply_edge(300 + i, mk(128, 1'b0, 0, 0, 1'b1));
        apply_edge(304, mk(128, 1'b1, 128, 2, mu(0)));

        // One-cycle reset while locked discards everything.
        rstn = 1'b0;
        cyc(1'b0);
        expect_now(400, 1'b0, 0, 0, 1'b1);
        rstn = 1'b1;
        for (int i = 0; i < 4; i++) apply_edge(401 + i, mk(128, 1'b0, 0, 0, 1'b1));
        apply_edge(405, mk(128, 1'b1, 128, 2, mu(0)));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pcm_wclk_lock_ctrl.md
# pcm_wclk_lock_ctrl

Lock detector and sequencing controller for the MCLK-domain PCM path. It measures the WCLK period in MCLK cycles, declares lock after a run of consistent periods, and classifies the MCLK/fs ratio. It drives a mute output that gates downstream consumers of the PCM_MCLK_SYNC outputs. It sits directly after the synchronizer, and its WCLK_I is that block's WCLK_O.

## Interface
- CNT_WIDTH, 12: period counter width; must be ≥ 11; max measurable period 2^CNT_WIDTH−1.
- LOCK_COUNT, 4: consecutive matching periods required for lock; range 2..15.
- TOL, 1: allowed |P − ref| in MCLK cycles.
- UNMUTE_FRAMES, 16: WCLK edges from lock to unmute; used only with PCM_LOCK_MUTE_EN.
- MCLK_I  in  1: master clock, sole clock.
- ARESETN_I  in  1: synchronous reset, active-low, sampled on MCLK_I rising edge.
- WCLK_I  in  1: word clock, already synchronous to MCLK_I.
- LOCK_O  out  1: period is stable.
- PERIOD_O  out  CNT_WIDTH: locked period in MCLK cycles; 0 when unlocked.
- RATE_O  out  3: 0 = unlocked, 1/2/3/4/5 = 64/128/256/512/1024 fs, 7 = locked at a non-standard ratio.
- MUTE_O  out  1: 1 = downstream must output silence.

## Operation
- The block registers WCLK_I once into wclk_d. An edge cycle is any cycle where WCLK_I=1 and wclk_d=0.
- Counter cnt loads 1 on an edge cycle, otherwise increments and saturates at 2^CNT_WIDTH−1. Measured period P = cnt before the update at an edge cycle, so P equals the number of MCLK cycles between edge cycles.
- States:
  - SEARCH: reset state. On the first edge cycle, go to MEASURE with no period recorded.
  - MEASURE: on each edge cycle, if run=0 or |P−ref|>TOL, set ref=P and run=1. Otherwise run++. When run reaches LOCK_COUNT, go to LOCKED, with PERIOD_O=ref and LOCK_O=1.
  - LOCKED: on an edge cycle with |P−PERIOD_O|>TOL, go to MEASURE with ref=P and run=1, and clear LOCK_O, PERIOD_O and RATE_O. An edge cycle within TOL changes nothing; PERIOD_O is not re-tracked.
- Timeout: in MEASURE or LOCKED, if cnt is saturated and there is no edge cycle, go to SEARCH and clear run, LOCK_O, PERIOD_O and RATE_O.
- Simultaneous edge and timeout: the edge takes priority and P = saturated value.
- RATE_O is computed from ref on entry to LOCKED. Code 1..5 applies if |ref − {64,128,256,512,1024}| ≤ TOL; otherwise the code is 7. RATE_O is held while LOCKED.
- The comparison |P−ref| uses unsigned CNT_WIDTH+1-bit subtraction, with no wrap.

## Timing
- All outputs are registered. Every state and output update takes effect at the clock edge that samples the edge cycle.
- Reset values: LOCK_O=0, PERIOD_O=0, RATE_O=0, MUTE_O=1; state=SEARCH, cnt=0, run=0, wclk_d=0.
- Lock latency from the first edge cycle is LOCK_COUNT further edge cycles.
- Loss of lock takes effect in the mismatching edge cycle, or in the timeout cycle.
- When ARESETN_I=0 mid-operation, all registers return to reset values at that clock edge, and any lock in progress is discarded.

## Configuration
- Macro PCM_LOCK_MUTE_EN.
- Defined:
  - An unmute counter starts when LOCK_O rises.
  - MUTE_O falls in the UNMUTE_FRAMES-th edge cycle after lock.
  - Any unlock, timeout or reset sets MUTE_O=1 in the same cycle LOCK_O clears and restarts the countdown from zero.
- Not defined: MUTE_O = ~LOCK_O, updated in the same cycle as LOCK_O. UNMUTE_FRAMES is ignored.

## Test plan
- Reset, then WCLK period 128 MCLK at 50% duty (defaults) -> LOCK_O=1 at the 5th edge cycle, PERIOD_O=128, RATE_O=2. MUTE_O: with the macro, 0 at the 21st edge cycle; without it, 0 at the 5th.
- Periods 128,129,127,128 -> lock with PERIOD_O=128. Then a single 131 period -> LOCK_O=0, RATE_O=0, PERIOD_O=0, MUTE_O=1 in that edge cycle.
- While locked at 128, hold WCLK_I high -> LOCK_O falls 4095 cycles after the last edge cycle and the state is SEARCH. On resuming, relock takes 5 edge cycles.
- Period 384 -> LOCK_O=1, PERIOD_O=384, RATE_O=7.
- While locked at 128, switch to period 256 -> unlock at the first 256 period. Relock 3 edge cycles later with PERIOD_O=256 and RATE_O=3.
- ARESETN_I=0 for one cycle while locked -> next cycle all outputs are at reset values. Relock requires 5 edge cycles.
